// File: rtl/decode.sv
// rtl/decode.sv - decode stage: register file, field/immediate decode, load-use stall, flush bubbles
module decode #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_in,
  input  logic [31:0] IR_in,
  input  logic        FLUSH,
  input  logic        WB_en,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_data,
  output logic [31:0] PC_out,
  output logic [31:0] RS1_val,
  output logic [31:0] RS2_val,
  output logic [31:0] IMM_out,
  output logic [4:0]  RD_out,
  output logic [6:0]  OPCODE_out,
  output logic [2:0]  FUNCT3_out,
  output logic [6:0]  FUNCT7_out,
  output logic        VALID_out,
  output logic        STALL_out
);

  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, rs1_rd, rs2_rd;
  logic        rs1_used, rs2_used;

  assign opcode = IR_in[6:0];
  assign rd     = IR_in[11:7];
  assign rs1    = IR_in[19:15];
  assign rs2    = IR_in[24:20];

  always_comb begin
    imm = '0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111:
        imm = {{20{IR_in[31]}}, IR_in[31:20]};
      7'b0100011:
        imm = {{20{IR_in[31]}}, IR_in[31:25], IR_in[11:7]};
      7'b1100011:
        imm = {{19{IR_in[31]}}, IR_in[31], IR_in[7], IR_in[30:25], IR_in[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {IR_in[31:12], 12'b0};
      7'b1101111:
        imm = {{11{IR_in[31]}}, IR_in[31], IR_in[19:12], IR_in[20], IR_in[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // Write-through: a same-cycle writeback to the source register wins over the stored value
  always_comb begin
    rs1_rd = regs[rs1];
    rs2_rd = regs[rs2];
    if (rs1 == 5'd0)
      rs1_rd = '0;
    else if (WB_en && WB_rd == rs1)
      rs1_rd = WB_data;
    if (rs2 == 5'd0)
      rs2_rd = '0;
    else if (WB_en && WB_rd == rs2)
      rs2_rd = WB_data;
  end

  assign rs1_used = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
  assign rs2_used = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);

  assign STALL_out = !FLUSH && VALID_out && OPCODE_out == 7'b0000011 && RD_out != 5'd0 &&
                     ((rs1_used && rs1 == RD_out) || (rs2_used && rs2 == RD_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (WB_en && WB_rd != 5'd0) begin
      regs[WB_rd] <= WB_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_out     <= '0;
      RS1_val    <= '0;
      RS2_val    <= '0;
      IMM_out    <= '0;
      RD_out     <= '0;
      OPCODE_out <= '0;
      FUNCT3_out <= '0;
      FUNCT7_out <= '0;
      VALID_out  <= 1'b0;
    end else if (FLUSH || STALL_out) begin
      PC_out     <= PC_in;
      RS1_val    <= '0;
      RS2_val    <= '0;
      IMM_out    <= '0;
      RD_out     <= '0;
      OPCODE_out <= NOP_INSTR[6:0];
      FUNCT3_out <= NOP_INSTR[14:12];
      FUNCT7_out <= NOP_INSTR[31:25];
      VALID_out  <= 1'b0;
    end else begin
      PC_out     <= PC_in;
      RS1_val    <= rs1_rd;
      RS2_val    <= rs2_rd;
      IMM_out    <= imm;
      RD_out     <= rd;
      OPCODE_out <= opcode;
      FUNCT3_out <= IR_in[14:12];
      FUNCT7_out <= IR_in[31:25];
      VALID_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - table-driven directed bench for decode
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_in, IR_in, WB_data;
  logic        FLUSH, WB_en;
  logic [4:0]  WB_rd;
  logic [31:0] PC_out, RS1_val, RS2_val, IMM_out;
  logic [4:0]  RD_out;
  logic [6:0]  OPCODE_out, FUNCT7_out;
  logic [2:0]  FUNCT3_out;
  logic        VALID_out, STALL_out;

  int checks = 0;
  int errors = 0;

  decode dut (
    .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .IR_in(IR_in), .FLUSH(FLUSH),
    .WB_en(WB_en), .WB_rd(WB_rd), .WB_data(WB_data), .PC_out(PC_out),
    .RS1_val(RS1_val), .RS2_val(RS2_val), .IMM_out(IMM_out), .RD_out(RD_out),
    .OPCODE_out(OPCODE_out), .FUNCT3_out(FUNCT3_out), .FUNCT7_out(FUNCT7_out),
    .VALID_out(VALID_out), .STALL_out(STALL_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_imm;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        chk_ops;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] ir, input logic flush,
                              input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                              input logic e_stall, input logic e_valid, input logic [4:0] e_rd,
                              input logic [31:0] e_imm, input logic [6:0] e_op, input logic [2:0] e_f3,
                              input logic chk_ops, input logic [31:0] e_rs1, input logic [31:0] e_rs2);
    vec_t v;
    v.pc = pc; v.ir = ir; v.flush = flush; v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_rd = e_rd; v.e_imm = e_imm; v.e_op = e_op;
    v.e_f3 = e_f3; v.chk_ops = chk_ops; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " PC_out"}, PC_out, 32'h0);
    chk({tag, " RS1_val"}, RS1_val, 32'h0);
    chk({tag, " RS2_val"}, RS2_val, 32'h0);
    chk({tag, " IMM_out"}, IMM_out, 32'h0);
    chk({tag, " RD_out"}, {27'h0, RD_out}, 32'h0);
    chk({tag, " OPCODE_out"}, {25'h0, OPCODE_out}, 32'h0);
    chk({tag, " VALID_out"}, {31'h0, VALID_out}, 32'h0);
  endtask

  task automatic drive(input vec_t v);
    PC_in = v.pc; IR_in = v.ir; FLUSH = v.flush;
    WB_en = v.wb_en; WB_rd = v.wb_rd; WB_data = v.wb_data;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, " VALID_out"}, {31'h0, VALID_out}, {31'h0, v.e_valid});
    chk({t, " PC_out"}, PC_out, v.pc);
    chk({t, " RD_out"}, {27'h0, RD_out}, {27'h0, v.e_rd});
    chk({t, " IMM_out"}, IMM_out, v.e_imm);
    chk({t, " OPCODE_out"}, {25'h0, OPCODE_out}, {25'h0, v.e_op});
    chk({t, " FUNCT3_out"}, {29'h0, FUNCT3_out}, {29'h0, v.e_f3});
    if (v.chk_ops) begin
      chk({t, " RS1_val"}, RS1_val, v.e_rs1);
      chk({t, " RS2_val"}, RS2_val, v.e_rs2);
    end
  endtask

  initial begin
    //             pc     ir            fl we rd  wdata         st vl rd  imm           op     f3 ck rs1           rs2
    vecs[0]  = mk(32'd8,  32'hFFF00093, 0, 0, 0,  32'h0,        0, 1, 1,  32'hFFFFFFFF, 7'h13, 0, 1, 32'h0,        32'h0);
    vecs[1]  = mk(32'd12, 32'h00028313, 0, 1, 5,  32'hDEADBEEF, 0, 1, 6,  32'h0,        7'h13, 0, 1, 32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(32'd16, 32'h02000393, 0, 1, 0,  32'h12345678, 0, 1, 7,  32'h20,       7'h13, 0, 1, 32'h0,        32'h0);
    vecs[3]  = mk(32'd20, 32'h00528433, 0, 1, 2,  32'h100,      0, 1, 8,  32'h0,        7'h33, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    vecs[4]  = mk(32'd24, 32'h00012183, 0, 1, 1,  32'h7,        0, 1, 3,  32'h0,        7'h03, 2, 1, 32'h100,      32'h0);
    vecs[5]  = mk(32'd28, 32'h00118233, 0, 1, 3,  32'h55,       1, 0, 0,  32'h0,        7'h13, 0, 1, 32'h0,        32'h0);
    vecs[6]  = mk(32'd28, 32'h00118233, 0, 0, 0,  32'h0,        0, 1, 4,  32'h0,        7'h33, 0, 1, 32'h55,       32'h7);
    vecs[7]  = mk(32'd32, 32'h00412183, 0, 0, 0,  32'h0,        0, 1, 3,  32'h4,        7'h03, 2, 1, 32'h100,      32'h0);
    vecs[8]  = mk(32'd36, 32'h000181B7, 0, 0, 0,  32'h0,        0, 1, 3,  32'h00018000, 7'h37, 0, 0, 32'h0,        32'h0);
    vecs[9]  = mk(32'd40, 32'hFE000EE3, 0, 0, 0,  32'h0,        0, 1, 29, 32'hFFFFFFFC, 7'h63, 0, 1, 32'h0,        32'h0);
    vecs[10] = mk(32'd44, 32'h001000EF, 0, 0, 0,  32'h0,        0, 1, 1,  32'h00000800, 7'h6F, 0, 0, 32'h0,        32'h0);
    vecs[11] = mk(32'd48, 32'hFE112C23, 0, 0, 0,  32'h0,        0, 1, 24, 32'hFFFFFFF8, 7'h23, 2, 1, 32'h100,      32'h7);
    vecs[12] = mk(32'd52, 32'h00012483, 0, 0, 0,  32'h0,        0, 1, 9,  32'h0,        7'h03, 2, 1, 32'h100,      32'h0);
    vecs[13] = mk(32'd56, 32'h00912023, 1, 0, 0,  32'h0,        0, 0, 0,  32'h0,        7'h13, 0, 1, 32'h0,        32'h0);
    vecs[14] = mk(32'd60, 32'h00012183, 0, 0, 0,  32'h0,        0, 1, 3,  32'h0,        7'h03, 2, 1, 32'h100,      32'h0);

    rst_n = 1'b0; PC_in = '0; IR_in = '0; FLUSH = 1'b0; WB_en = 1'b0; WB_rd = '0; WB_data = '0;
    #2;
    chk_zero_outputs("reset");
    chk("reset STALL_out", {31'h0, STALL_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d STALL_out", i), {31'h0, STALL_out}, {31'h0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end

    // Load-use hazard pending, then an asynchronous reset between edges
    @(negedge clk);
    PC_in = 32'd64; IR_in = 32'h00118233; FLUSH = 1'b0; WB_en = 1'b0;
    #1;
    chk("pre-reset STALL_out", {31'h0, STALL_out}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    chk("async reset STALL_out", {31'h0, STALL_out}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset VALID_out", {31'h0, VALID_out}, 32'h1);
    chk("post-reset RD_out", {27'h0, RD_out}, 32'd4);
    chk("post-reset PC_out", PC_out, 32'd64);
    chk("post-reset RS1_val x3", RS1_val, 32'h0);
    chk("post-reset RS2_val x1", RS2_val, 32'h0);

    @(negedge clk);
    PC_in = 32'd68; IR_in = 32'h00528433;
    @(posedge clk);
    #1;
    chk("post-reset RS1_val x5", RS1_val, 32'h0);
    chk("post-reset RS2_val x5", RS2_val, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: NOP_INSTR, 32'h00000013, instruction encoding recorded in OPCODE/FUNCT fields when a bubble is inserted (addi x0,x0,0).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 PC_in  input  32  PC of instruction from fetch stage.
REQ-005 IR_in  input  32  instruction word from fetch stage.
REQ-006 FLUSH  input  1  taken branch/jump from execute (the fetch-redirect condition); kill the instruction in decode.
REQ-007 WB_en  input  1  writeback enable.
REQ-008 WB_rd  input  5  writeback destination register.
REQ-009 WB_data  input  32  writeback data.
REQ-010 PC_out  output  32  registered PC to execute.
REQ-011 RS1_val, RS2_val  output  32 each  registered source operand values.
REQ-012 IMM_out  output  32  registered sign-extended immediate.
REQ-013 RD_out  output  5  registered destination register.
REQ-014 OPCODE_out  output  7; FUNCT3_out  output  3; FUNCT7_out  output  7  registered instruction fields.
REQ-015 VALID_out  output  1  registered; 1 = outputs carry a real instruction.
REQ-016 STALL_out  output  1  combinational; 1 = fetch holds PC and IR for one more cycle.

Function
REQ-017 Register file 32 x 32 bit; x0 reads 0; writes with WB_rd=0 ignored; write on rising clk when WB_en=1.
REQ-018 Write-through bypass: same-cycle read of rs1/rs2 equal to WB_rd (non-zero, WB_en=1) returns WB_data, not the old value.
REQ-019 Field decode: rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7], funct3=IR[14:12], funct7=IR[31:25], opcode=IR[6:0].
REQ-020 Immediate: I (0010011, 0000011, 1100111) = sext IR[31:20]; S (0100011) = sext {IR[31:25],IR[11:7]}; B (1100011) = sext {IR[31],IR[7],IR[30:25],IR[11:8],0}; U (0110111, 0010111) = {IR[31:12],12'b0}; J (1101111) = sext {IR[31],IR[19:12],IR[20],IR[30:21],0}; all others 0.
REQ-021 Latency: one cycle; fields of IR_in present before edge N appear on outputs after edge N.
REQ-022 rs1 used by all opcodes except 0110111, 0010111, 1101111; rs2 used only by 0110011, 0100011, 1100011.
REQ-023 Load-use hazard: STALL_out=1 when VALID_out=1, OPCODE_out=0000011, RD_out!=0, and RD_out equals a used rs1/rs2 of IR_in.
REQ-024 On edge with STALL_out=1: outputs load a bubble; fetch re-presents the same PC/IR next cycle; bubble clears the hazard, so stall lasts exactly one cycle.
REQ-025 Bubble: VALID_out=0, RD_out=0, RS1_val=RS2_val=IMM_out=0, OPCODE/FUNCT3/FUNCT7 from NOP_INSTR, PC_out=PC_in.
REQ-026 FLUSH=1 at an edge: outputs load a bubble; FLUSH has priority over stall; STALL_out forced 0 while FLUSH=1.
REQ-027 Register-file write proceeds during stall and flush cycles.

Reset
REQ-028 rst_n=0 immediately forces all registered outputs to 0 (including VALID_out=0) and all 32 registers to 0, independent of clk.
REQ-029 First edge after rst_n rises decodes IR_in normally; reset mid-stall discards the stall.

Verification
REQ-030 IR_in=32'hFFF00093 (addi x1,x0,-1), PC_in=8 -> next edge: RD_out=1, IMM_out=FFFFFFFF, RS1_val=0, VALID_out=1, PC_out=8.
REQ-031 WB_en=1, WB_rd=5, WB_data=32'hDEADBEEF same cycle as IR reading rs1=5 -> RS1_val=DEADBEEF; WB_rd=0 write then read x0 -> 0.
REQ-032 lw x3,0(x2) then add x4,x3,x1 -> STALL_out=1 one cycle, bubble (VALID_out=0) emitted, add issues next cycle; lui x3 after lw -> no stall.
REQ-033 FLUSH=1 with valid IR_in and concurrent load-use hazard -> VALID_out=0, STALL_out=0.
REQ-034 Branch beq imm=-4 (IR=32'hFE000EE3) -> IMM_out=FFFFFFFC; jal imm=+2048 -> IMM_out=00000800.
REQ-035 rst_n pulsed low between edges after register writes -> outputs and all registers read 0 immediately.
